rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
- Shares the single asynchronous instruction ROM read port between two requesters: instruction fetch (IF) and a debug/data read port (DBG).
- Grants at most one read per cycle, with fixed priority to IF and a starvation guard for DBG.
- Drives the ROM address and read-enable combinationally, then registers the returned word toward the winning requester.
- Sits between the fetch stage and the ROM in the single-cycle and later pipelined cores.

Parameters:
- TAM_POSICIONES, 1024, number of ROM words; the address width is $clog2(TAM_POSICIONES).
- TAM_PALABRA, 32, ROM word width in bits.
- MAX_WAIT, 4, number of consecutive cycles DBG may be refused before it takes priority; must be at least 1.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- IF_REQ  input  1  IF read request, level.
- IF_ADDR  input  $clog2(TAM_POSICIONES)  IF word address.
- IF_GNT  output  1  combinational; the IF request is accepted this cycle.
- IF_ACK  output  1  registered; IF_RDATA is valid this cycle.
- IF_RDATA  output  TAM_PALABRA  registered read data for IF.
- DBG_REQ  input  1  DBG read request, level.
- DBG_ADDR  input  $clog2(TAM_POSICIONES)  DBG word address.
- DBG_GNT  output  1  combinational DBG accept.
- DBG_ACK  output  1  registered; DBG_RDATA is valid.
- DBG_RDATA  output  TAM_PALABRA  registered read data for DBG.
- ROM_ADDR  output  $clog2(TAM_POSICIONES)  address to the ROM's INS_ADDRESS.
- ROM_READ_EN  output  1  to the ROM's READ_EN.
- ROM_DATA  input  TAM_PALABRA  from the ROM's INSTRUCTION_OUT.
- CONFLICT_CNT  output  16  saturating count of cycles in which both requests were high.

Behaviour:
- Reset (asynchronous, RST=1):
  - IF_ACK=0, DBG_ACK=0, IF_RDATA=0, DBG_RDATA=0, CONFLICT_CNT=0.
  - Starvation counter WAIT_CNT=0.
  - Any in-flight response is discarded; no ACK is issued for it after reset releases.
- Arbitration (combinational, each cycle):
  - DBG_PRIO = (WAIT_CNT == MAX_WAIT).
  - DBG_PRIO=1 and DBG_REQ=1: DBG wins.
  - Otherwise IF_REQ=1: IF wins.
  - Otherwise DBG_REQ=1: DBG wins.
  - Otherwise no grant.
  - IF_GNT and DBG_GNT are one-hot or zero and never both high.
- ROM drive:
  - ROM_READ_EN = IF_GNT | DBG_GNT.
  - ROM_ADDR = address of the winner, or 0 when there is no grant.
  - ROM_DATA is sampled in the same cycle, since the ROM is asynchronous.
- Response (1-cycle latency):
  - Grant in cycle N gives {X}_RDATA <= ROM_DATA and {X}_ACK=1 in cycle N+1, for exactly one cycle.
  - {X}_RDATA holds its value until the next ACK for that requester.
  - The non-granted requester's ACK is 0.
- Handshake:
  - A request is consumed on the rising edge where its GNT=1.
  - The requester may present a new ADDR/REQ in the following cycle, including the ACK cycle. This allows back-to-back throughput of 1 read per cycle.
  - A refused request must hold REQ and ADDR stable until granted.
  - Dropping REQ without a grant is legal; nothing is issued for it.
- Starvation counter:
  - DBG_REQ=1 and DBG_GNT=0: WAIT_CNT increments, saturating at MAX_WAIT.
  - DBG_GNT=1 or DBG_REQ=0: WAIT_CNT clears to 0.
- CONFLICT_CNT: increments when IF_REQ & DBG_REQ, and saturates at 16'hFFFF.
- The arbiter FSM is implied by WAIT_CNT; there is no other state beyond the response registers.

Test Plan:
- Reset, IF only: assert RST mid-run → all ACK/RDATA/CONFLICT_CNT are 0 immediately. Release, IF_REQ=1, IF_ADDR=3 with ROM[3]=32'h00500093 → IF_GNT=1, ROM_READ_EN=1, ROM_ADDR=3 same cycle; IF_ACK=1 and IF_RDATA=32'h00500093 next cycle.
- Back-to-back IF: IF addresses 0,1,2,3 on consecutive cycles → four consecutive IF_ACK pulses carrying ROM[0..3] in order, each one cycle after its grant.
- Conflict: both requesters continuously requesting, MAX_WAIT=4 → IF granted 4 cycles, DBG granted cycle 5, then IF resumes; CONFLICT_CNT=5 after 5 cycles.
- Idle: no requests → ROM_READ_EN=0, ROM_ADDR=0, no ACK.
- Reset mid-operation: assert RST in the cycle after a DBG grant → DBG_ACK stays 0 and DBG_RDATA=0.
- Saturation: force 70000 conflict cycles → CONFLICT_CNT=16'hFFFF and holds there.

Source files
------------

// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if: request/grant/response bundle between the two ROM requesters, the arbiter and the ROM.
interface rom_port_arbiter_if #(
  parameter int TAM_POSICIONES = 1024,
  parameter int TAM_PALABRA    = 32
);
  localparam int AW = $clog2(TAM_POSICIONES);
  logic                   IF_REQ;
  logic [AW-1:0]          IF_ADDR;
  logic                   IF_GNT;
  logic                   IF_ACK;
  logic [TAM_PALABRA-1:0] IF_RDATA;
  logic                   DBG_REQ;
  logic [AW-1:0]          DBG_ADDR;
  logic                   DBG_GNT;
  logic                   DBG_ACK;
  logic [TAM_PALABRA-1:0] DBG_RDATA;
  logic [AW-1:0]          ROM_ADDR;
  logic                   ROM_READ_EN;
  logic [TAM_PALABRA-1:0] ROM_DATA;
  logic [15:0]            CONFLICT_CNT;
  modport master (
    output IF_REQ, IF_ADDR, DBG_REQ, DBG_ADDR, ROM_DATA,
    input  IF_GNT, IF_ACK, IF_RDATA, DBG_GNT, DBG_ACK, DBG_RDATA, ROM_ADDR, ROM_READ_EN, CONFLICT_CNT
  );
  modport slave (
    input  IF_REQ, IF_ADDR, DBG_REQ, DBG_ADDR, ROM_DATA,
    output IF_GNT, IF_ACK, IF_RDATA, DBG_GNT, DBG_ACK, DBG_RDATA, ROM_ADDR, ROM_READ_EN, CONFLICT_CNT
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the asynchronous ROM read port between IF (fixed priority) and DBG (starvation-guarded).
module rom_port_arbiter #(
  parameter int TAM_POSICIONES = 1024,
  parameter int TAM_PALABRA    = 32,
  parameter int MAX_WAIT       = 4
) (
  input logic CLK,
  input logic RST,
  rom_port_arbiter_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic dbg_prio, if_gnt, dbg_gnt;
  always_ff @(posedge CLK or posedge RST)
    if (RST) wait_cnt <= '0;
    else wait_cnt <= wait_nxt;
  always_comb begin
    wait_nxt = '0;
    if (bus.DBG_REQ && !dbg_gnt) wait_nxt = dbg_prio ? wait_cnt : wait_cnt + WW'(1);
  end
  always_comb begin
    dbg_prio = wait_cnt == WW'(MAX_WAIT);
    dbg_gnt  = bus.DBG_REQ && (dbg_prio || !bus.IF_REQ);
    if_gnt   = bus.IF_REQ && !dbg_gnt;
  end
  assign bus.IF_GNT      = if_gnt;
  assign bus.DBG_GNT     = dbg_gnt;
  assign bus.ROM_READ_EN = if_gnt | dbg_gnt;
  assign bus.ROM_ADDR    = if_gnt ? bus.IF_ADDR : dbg_gnt ? bus.DBG_ADDR : '0;
  // the ROM answers in the grant cycle, so the word is captured on the consuming edge
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      bus.IF_ACK       <= 1'b0;
      bus.DBG_ACK      <= 1'b0;
      bus.IF_RDATA     <= '0;
      bus.DBG_RDATA    <= '0;
      bus.CONFLICT_CNT <= '0;
    end else begin
      bus.IF_ACK  <= if_gnt;
      bus.DBG_ACK <= dbg_gnt;
      if (if_gnt) bus.IF_RDATA <= bus.ROM_DATA;
      if (dbg_gnt) bus.DBG_RDATA <= bus.ROM_DATA;
      if (bus.IF_REQ && bus.DBG_REQ && !(&bus.CONFLICT_CNT)) bus.CONFLICT_CNT <= bus.CONFLICT_CNT + 16'd1;
    end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: randomized and directed checks of rom_port_arbiter against a cycle-level behavioural model.
module tb_rom_port_arbiter;
  localparam int N  = 1024;
  localparam int W  = 32;
  localparam int MW = 4;
  localparam int AW = $clog2(N);
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] rom [N];
  rom_port_arbiter_if #(.TAM_POSICIONES(N), .TAM_PALABRA(W)) bus ();
  rom_port_arbiter #(.TAM_POSICIONES(N), .TAM_PALABRA(W), .MAX_WAIT(MW)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  assign bus.ROM_DATA = rom[bus.ROM_ADDR];
  always #5 CLK = ~CLK;
  logic e_if_gnt, e_dbg_gnt, e_en, e_if_ack, e_dbg_ack;
  logic [AW-1:0] e_addr;
  logic [W-1:0] e_if_rdata, e_dbg_rdata;
  int refusals, e_cnt;
  task automatic predict();
    e_dbg_gnt = bus.DBG_REQ && (refusals >= MW || !bus.IF_REQ);
    e_if_gnt  = bus.IF_REQ && !e_dbg_gnt;
    e_en      = e_if_gnt || e_dbg_gnt;
    e_addr    = e_if_gnt ? bus.IF_ADDR : e_dbg_gnt ? bus.DBG_ADDR : '0;
  endtask
  task automatic tick();
    predict();
    @(posedge CLK);
    e_if_ack  = e_if_gnt;
    e_dbg_ack = e_dbg_gnt;
    if (e_if_gnt) e_if_rdata = rom[bus.IF_ADDR];
    if (e_dbg_gnt) e_dbg_rdata = rom[bus.DBG_ADDR];
    refusals = (bus.DBG_REQ && !e_dbg_gnt) ? refusals + 1 : 0;
    if (bus.IF_REQ && bus.DBG_REQ && e_cnt < 65535) e_cnt++;
    #1;
  endtask
  task automatic model_reset();
    e_if_ack = 0; e_dbg_ack = 0; e_if_rdata = '0; e_dbg_rdata = '0; e_cnt = 0; refusals = 0;
  endtask
  task automatic drive(input logic ir, input int ia, input logic dr, input int da);
    bus.IF_REQ = ir; bus.IF_ADDR = AW'(ia); bus.DBG_REQ = dr; bus.DBG_ADDR = AW'(da);
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0);
    RST = 1'b1;
    model_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask
  task automatic test_reset();
    drive(1, 3, 1, 7);
    tick(); tick();
    RST = 1'b1;
    #2;
    checks++;
    if (bus.IF_ACK !== 1'b0 || bus.DBG_ACK !== 1'b0) begin errors++; $display("FAIL reset_ack: got if=%b dbg=%b, want 0 0", bus.IF_ACK, bus.DBG_ACK); end
    checks++;
    if (bus.IF_RDATA !== '0 || bus.DBG_RDATA !== '0) begin errors++; $display("FAIL reset_rdata: got if=%h dbg=%h, want 0 0", bus.IF_RDATA, bus.DBG_RDATA); end
    checks++;
    if (bus.CONFLICT_CNT !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d, want 0", bus.CONFLICT_CNT); end
    do_reset();
  endtask
  task automatic test_if_only();
    rom[3] = 32'h00500093;
    drive(1, 3, 0, 0);
    #1;
    checks++;
    if (bus.IF_GNT !== 1'b1 || bus.DBG_GNT !== 1'b0 || bus.ROM_READ_EN !== 1'b1 || bus.ROM_ADDR !== AW'(3)) begin
      errors++; $display("FAIL if_only_grant: got gnt=%b/%b en=%b addr=%0d, want 1/0 1 3", bus.IF_GNT, bus.DBG_GNT, bus.ROM_READ_EN, bus.ROM_ADDR);
    end
    tick();
    drive(0, 0, 0, 0);
    checks++;
    if (bus.IF_ACK !== 1'b1 || bus.IF_RDATA !== 32'h00500093 || bus.DBG_ACK !== 1'b0) begin
      errors++; $display("FAIL if_only_resp: got ack=%b data=%h dbg_ack=%b, want 1 00500093 0", bus.IF_ACK, bus.IF_RDATA, bus.DBG_ACK);
    end
    tick();
    checks++;
    if (bus.IF_ACK !== 1'b0 || bus.IF_RDATA !== 32'h00500093) begin
      errors++; $display("FAIL if_only_hold: got ack=%b data=%h, want 0 00500093", bus.IF_ACK, bus.IF_RDATA);
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1, i, 0, 0); else drive(0, 0, 0, 0);
      #1;
      checks++;
      if (i < 4 && (bus.IF_GNT !== 1'b1 || bus.ROM_ADDR !== AW'(i))) begin
        errors++; $display("FAIL b2b_grant[%0d]: got gnt=%b addr=%0d, want 1 %0d", i, bus.IF_GNT, bus.ROM_ADDR, i);
      end
      checks++;
      if (i > 0 && (bus.IF_ACK !== 1'b1 || bus.IF_RDATA !== rom[i-1])) begin
        errors++; $display("FAIL b2b_ack[%0d]: got ack=%b data=%h, want 1 %h", i, bus.IF_ACK, bus.IF_RDATA, rom[i-1]);
      end
      tick();
    end
  endtask
  task automatic test_conflict();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 100 + i, 1, 200);
      #1;
      checks++;
      if (bus.DBG_GNT !== logic'(i == 4 || i == 9) || bus.IF_GNT !== logic'(!(i == 4 || i == 9))) begin
        errors++; $display("FAIL conflict_grant[%0d]: got if=%b dbg=%b, want dbg=%b", i, bus.IF_GNT, bus.DBG_GNT, i == 4 || i == 9);
      end
      tick();
      if (i == 4) begin
        checks++;
        if (bus.CONFLICT_CNT !== 16'd5 || bus.DBG_ACK !== 1'b1 || bus.DBG_RDATA !== rom[200]) begin
          errors++; $display("FAIL conflict_cnt5: got cnt=%0d dbg_ack=%b data=%h, want 5 1 %h", bus.CONFLICT_CNT, bus.DBG_ACK, bus.DBG_RDATA, rom[200]);
        end
      end
    end
    drive(0, 0, 0, 0);
    tick();
  endtask
  task automatic test_idle();
    drive(0, 55, 0, 66);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.ROM_READ_EN !== 1'b0 || bus.ROM_ADDR !== '0 || bus.IF_GNT !== 1'b0 || bus.DBG_GNT !== 1'b0) begin
        errors++; $display("FAIL idle_drive: got en=%b addr=%0d gnt=%b/%b, want 0 0 0/0", bus.ROM_READ_EN, bus.ROM_ADDR, bus.IF_GNT, bus.DBG_GNT);
      end
      tick();
      checks++;
      if (bus.IF_ACK !== 1'b0 || bus.DBG_ACK !== 1'b0) begin
        errors++; $display("FAIL idle_ack: got %b/%b, want 0/0", bus.IF_ACK, bus.DBG_ACK);
      end
    end
  endtask
  task automatic test_reset_mid();
    drive(0, 0, 1, 9);
    tick();
    drive(0, 0, 1, 10);
    RST = 1'b1;
    #1;
    checks++;
    if (bus.DBG_ACK !== 1'b0 || bus.DBG_RDATA !== '0) begin
      errors++; $display("FAIL reset_mid: got ack=%b data=%h, want 0 0", bus.DBG_ACK, bus.DBG_RDATA);
    end
    drive(0, 0, 0, 0);
    model_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
    tick();
    checks++;
    if (bus.DBG_ACK !== 1'b0 || bus.DBG_RDATA !== '0) begin
      errors++; $display("FAIL reset_mid_after: got ack=%b data=%h, want 0 0", bus.DBG_ACK, bus.DBG_RDATA);
    end
  endtask
  task automatic test_random();
    logic ir, dr;
    int ia, da;
    ir = 0; dr = 0; ia = 0; da = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(ir && !e_if_gnt && $urandom_range(0, 9) != 0)) begin ir = logic'($urandom_range(0, 2) != 0); ia = $urandom_range(0, N - 1); end
      if (!(dr && !e_dbg_gnt && $urandom_range(0, 9) != 0)) begin dr = logic'($urandom_range(0, 1)); da = $urandom_range(0, N - 1); end
      drive(ir, ia, dr, da);
      predict();
      #1;
      checks++;
      if (bus.IF_GNT !== e_if_gnt || bus.DBG_GNT !== e_dbg_gnt || bus.ROM_READ_EN !== e_en || bus.ROM_ADDR !== e_addr) begin
        errors++; $display("FAIL rand_comb[%0d]: got gnt=%b/%b en=%b addr=%0d, want %b/%b %b %0d", i, bus.IF_GNT, bus.DBG_GNT, bus.ROM_READ_EN, bus.ROM_ADDR, e_if_gnt, e_dbg_gnt, e_en, e_addr);
      end
      tick();
      checks++;
      if (bus.IF_ACK !== e_if_ack || bus.DBG_ACK !== e_dbg_ack || bus.IF_RDATA !== e_if_rdata || bus.DBG_RDATA !== e_dbg_rdata || bus.CONFLICT_CNT !== 16'(e_cnt)) begin
        errors++; $display("FAIL rand_resp[%0d]: got ack=%b/%b data=%h/%h cnt=%0d, want %b/%b %h/%h %0d", i, bus.IF_ACK, bus.DBG_ACK, bus.IF_RDATA, bus.DBG_RDATA, bus.CONFLICT_CNT, e_if_ack, e_dbg_ack, e_if_rdata, e_dbg_rdata, e_cnt);
      end
    end
    drive(0, 0, 0, 0);
    tick();
  endtask
  task automatic test_saturation();
    do_reset();
    drive(1, 1, 1, 2);
    for (int i = 0; i < 70000; i++) tick();
    checks++;
    if (bus.CONFLICT_CNT !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h, want ffff", bus.CONFLICT_CNT); end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bus.CONFLICT_CNT !== 16'hFFFF || e_cnt != 65535) begin errors++; $display("FAIL sat_hold: got %h, want ffff", bus.CONFLICT_CNT); end
    drive(0, 0, 0, 0);
    tick();
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < N; i++) rom[i] = $urandom;
    do_reset();
    test_reset();
    test_if_only();
    test_back_to_back();
    test_conflict();
    test_idle();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
